sa_out_drain: RTL and testbench

SA_OUT_DRAIN -- requirements
Module: sa_out_drain

---
 rtl/sa_pkg.sv | 13 +
 rtl/sa_row_mux.sv | 26 ++
 rtl/sa_out_drain.sv | 112 +++++++++++
 tb/tb_sa_out_drain.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared sizing defaults and drain FSM encoding for the systolic-array output path.
package sa_pkg;

   localparam int D_W_DEF  = 16;
   localparam int SA_R_DEF = 16;
   localparam int SA_C_DEF = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

endpackage

// File: rtl/sa_row_mux.sv
// Combinational row picker: selects one SA_C-element row out of the flop-held tile.
module sa_row_mux
   import sa_pkg::*;
#(
   parameter int D_W   = D_W_DEF,
   parameter int SA_R  = SA_R_DEF,
   parameter int SA_C  = SA_C_DEF,
   parameter int IDX_W = (SA_R > 1) ? $clog2(SA_R) : 1
) (
   input  logic [SA_R*SA_C*D_W-1:0] tile_i,
   input  logic [IDX_W-1:0]         idx_i,
   output logic [SA_C*D_W-1:0]      row_o
);

   localparam int ROW_W = SA_C * D_W;

   always_comb begin
      row_o = '0;
      for (int r = 0; r < SA_R; r++) begin
         if (idx_i == IDX_W'(r)) begin
            row_o = tile_i[r*ROW_W +: ROW_W];
         end
      end
   end

endmodule

// File: rtl/sa_out_drain.sv
// Holds one result tile from the systolic array and streams it out row by row
// over a valid/ready handshake; back-to-back tiles chain without a bubble.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no tile held, waiting for I_OUT_VLD
//   SEND    | tile held, presenting row cnt_q until handshake on last row
module sa_out_drain
   import sa_pkg::*;
#(
   parameter int D_W  = D_W_DEF,
   parameter int SA_R = SA_R_DEF,
   parameter int SA_C = SA_C_DEF,
   localparam int IDX_W = (SA_R > 1) ? $clog2(SA_R) : 1
) (
   input  logic                     I_CLK,
   input  logic                     I_ASYN_RST,
   input  logic                     I_OUT_VLD,
   input  logic [SA_R*SA_C*D_W-1:0] I_OUT,
   input  logic                     I_ROW_RDY,
   output logic                     O_ROW_VLD,
   output logic [SA_C*D_W-1:0]      O_ROW,
   output logic [IDX_W-1:0]         O_ROW_IDX,
   output logic                     O_ROW_LAST,
   output logic                     O_BUSY,
   output logic                     O_OVF
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SA_R - 1);

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          cnt_q, cnt_d;
   logic [SA_R*SA_C*D_W-1:0]  tile_q, tile_d;
   logic                      ovf_q, ovf_d;
   logic                      load;
   logic                      hs;
   logic                      at_last;

   assign hs      = (state_q == ST_SEND) && I_ROW_RDY;
   assign at_last = (cnt_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      load    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (I_OUT_VLD) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (hs && at_last) begin
               // A tile arriving on the final handshake chains straight in.
               cnt_d = '0;
               if (I_OUT_VLD) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               if (hs) begin
                  cnt_d = cnt_q + IDX_W'(1);
               end
               if (I_OUT_VLD) begin
                  ovf_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign tile_d = load ? I_OUT : tile_q;

   always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
      if (I_ASYN_RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tile_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tile_q  <= tile_d;
         ovf_q   <= ovf_d;
      end
   end

   sa_row_mux #(
      .D_W   (D_W),
      .SA_R  (SA_R),
      .SA_C  (SA_C),
      .IDX_W (IDX_W)
   ) u_row_mux (
      .tile_i (tile_q),
      .idx_i  (cnt_q),
      .row_o  (O_ROW)
   );

   assign O_ROW_VLD  = (state_q == ST_SEND);
   assign O_BUSY     = (state_q == ST_SEND);
   assign O_ROW_LAST = (state_q == ST_SEND) && at_last;
   assign O_ROW_IDX  = cnt_q;
   assign O_OVF      = ovf_q;

endmodule

// File: tb/tb_sa_out_drain.sv
// Directed bench for sa_out_drain at default 16x16x16 sizing.
module tb_sa_out_drain;

   localparam int D_W  = 16;
   localparam int SA_R = 16;
   localparam int SA_C = 16;
   localparam int ROW_W  = SA_C * D_W;
   localparam int TILE_W = SA_R * ROW_W;

   logic              clk;
   logic              rst;
   logic              out_vld;
   logic [TILE_W-1:0] out_tile;
   logic              row_rdy;
   logic              row_vld;
   logic [ROW_W-1:0]  row;
   logic [3:0]        row_idx;
   logic              row_last;
   logic              busy;
   logic              ovf;

   logic [TILE_W-1:0] tile1;
   logic [TILE_W-1:0] tile2;
   logic [ROW_W-1:0]  row_7fff;
   logic [3:0]        rdy_pat;

   int errors = 0;
   int checks = 0;

   sa_out_drain #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) dut (
      .I_CLK      (clk),
      .I_ASYN_RST (rst),
      .I_OUT_VLD  (out_vld),
      .I_OUT      (out_tile),
      .I_ROW_RDY  (row_rdy),
      .O_ROW_VLD  (row_vld),
      .O_ROW      (row),
      .O_ROW_IDX  (row_idx),
      .O_ROW_LAST (row_last),
      .O_BUSY     (busy),
      .O_OVF      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ROW_W-1:0] exp_row1(input int r);
      logic [ROW_W-1:0] v;
      for (int c = 0; c < SA_C; c++) v[c*D_W +: D_W] = 16'(256 * r + c);
      return v;
   endfunction

   task automatic pulse_tile(input logic [TILE_W-1:0] t);
      out_tile = t;
      out_vld  = 1'b1;
      tick();
      out_vld  = 1'b0;
      out_tile = {128{$urandom()}};
   endtask

   initial begin
      int exp_idx;
      int k;
      bit done;

      for (int r = 0; r < SA_R; r++)
         for (int c = 0; c < SA_C; c++)
            tile1[(r*SA_C + c)*D_W +: D_W] = 16'(256 * r + c);
      for (int c = 0; c < SA_C; c++) row_7fff[c*D_W +: D_W] = 16'h7FFF;
      tile2 = {SA_R{row_7fff}};
      rdy_pat = 4'b1001;

      rst = 1'b1; out_vld = 1'b0; row_rdy = 1'b0; out_tile = tile1;
      tick(); tick();
      chk("rst_vld", ROW_W'(row_vld), '0);
      chk("rst_busy", ROW_W'(busy), '0);
      chk("rst_ovf", ROW_W'(ovf), '0);
      chk("rst_idx", ROW_W'(row_idx), '0);
      chk("rst_last", ROW_W'(row_last), '0);
      chk("rst_row", row, '0);
      rst = 1'b0;

      // Idle: ready and stray tile data must not matter
      row_rdy = 1'b1;
      tick(); tick();
      chk("idle_vld", ROW_W'(row_vld), '0);
      chk("idle_row", row, '0);
      chk("idle_idx", ROW_W'(row_idx), '0);

      // Full drain with ready held high
      pulse_tile(tile1);
      chk("t1_vld_rise", ROW_W'(row_vld), 1);
      chk("t1_busy", ROW_W'(busy), 1);
      for (int r = 0; r < SA_R; r++) begin
         chk($sformatf("t1_idx%0d", r), ROW_W'(row_idx), ROW_W'(r));
         chk($sformatf("t1_row%0d", r), row, exp_row1(r));
         chk($sformatf("t1_last%0d", r), ROW_W'(row_last), ROW_W'(r == SA_R - 1));
         if (r == 3) chk("t1_r3c5", ROW_W'(row[5*D_W +: D_W]), ROW_W'(16'h0305));
         tick();
      end
      chk("t1_vld_fall", ROW_W'(row_vld), '0);
      chk("t1_busy_fall", ROW_W'(busy), '0);
      chk("t1_idx_wrap", ROW_W'(row_idx), '0);

      // Stalled drain: ready pattern 1,0,0,1 repeating
      row_rdy = 1'b0;
      pulse_tile(tile1);
      exp_idx = 0; k = 0; done = 0;
      while (!done && k < 200) begin
         row_rdy = rdy_pat[3 - (k % 4)];
         chk($sformatf("st_vld_c%0d", k), ROW_W'(row_vld), 1);
         chk($sformatf("st_idx_c%0d", k), ROW_W'(row_idx), ROW_W'(exp_idx));
         chk($sformatf("st_row_c%0d", k), row, exp_row1(exp_idx));
         tick();
         if (row_rdy) begin
            if (exp_idx == SA_R - 1) done = 1;
            else exp_idx++;
         end
         k++;
      end
      chk("st_done_in_budget", ROW_W'(done), 1);
      chk("st_vld_fall", ROW_W'(row_vld), '0);

      // Chained tile on the final handshake
      row_rdy = 1'b1;
      pulse_tile(tile1);
      for (int r = 0; r < SA_R - 1; r++) tick();
      chk("ch_idx15", ROW_W'(row_idx), 15);
      chk("ch_last", ROW_W'(row_last), 1);
      pulse_tile(tile2);
      chk("ch_vld", ROW_W'(row_vld), 1);
      chk("ch_idx0", ROW_W'(row_idx), '0);
      chk("ch_row0", row, row_7fff);
      chk("ch_ovf", ROW_W'(ovf), '0);
      for (int r = 0; r < SA_R; r++) begin
         chk($sformatf("ch_t2_row%0d", r), row, row_7fff);
         tick();
      end
      chk("ch_vld_fall", ROW_W'(row_vld), '0);
      chk("ch_ovf_end", ROW_W'(ovf), '0);

      // Tile arriving mid-drain is dropped
      pulse_tile(tile1);
      for (int r = 0; r < 4; r++) tick();
      chk("ov_idx4", ROW_W'(row_idx), 4);
      pulse_tile(tile2);
      chk("ov_flag", ROW_W'(ovf), 1);
      for (int r = 5; r < SA_R; r++) begin
         chk($sformatf("ov_idx%0d", r), ROW_W'(row_idx), ROW_W'(r));
         chk($sformatf("ov_row%0d", r), row, exp_row1(r));
         tick();
      end
      chk("ov_vld_fall", ROW_W'(row_vld), '0);
      tick(); tick();
      chk("ov_sticky", ROW_W'(ovf), 1);

      // Asynchronous reset mid-tile
      pulse_tile(tile1);
      for (int r = 0; r < 7; r++) tick();
      chk("ar_idx7", ROW_W'(row_idx), 7);
      chk("ar_ovf_pre", ROW_W'(ovf), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_vld", ROW_W'(row_vld), '0);
      chk("ar_busy", ROW_W'(busy), '0);
      chk("ar_ovf", ROW_W'(ovf), '0);
      chk("ar_idx", ROW_W'(row_idx), '0);
      chk("ar_row", row, '0);
      tick();
      rst = 1'b0;
      tick(); tick();
      chk("ar_post_vld", ROW_W'(row_vld), '0);
      chk("ar_post_row", row, '0);
      pulse_tile(tile2);
      chk("ar_new_vld", ROW_W'(row_vld), 1);
      chk("ar_new_row", row, row_7fff);
      chk("ar_new_idx", ROW_W'(row_idx), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
